// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder: synchronises the raw PS/2 lines, assembles 11-bit frames into a
// byte FIFO, and decodes E0/F0 prefixed scan codes into make/break events with a press counter.
// Latency: o_valid/o_brk rise 2 cycles after the FIFO write when the FIFO was empty.
// Backpressure: i_pause=1 stops popping; a write to a full FIFO is dropped and sets sticky o_overflow.
// Optional feature: define PS2_PARITY_CHECK_EN to drop odd-parity failures and pulse o_parity_err.
module ps2_kbd_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 i_pause,
  output logic [7:0]           o_code,
  output logic                 o_ext,
  output logic                 o_pressed,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_valid,
  output logic                 o_brk,
  output logic                 o_ready,
  output logic                 o_overflow,
  output logic                 o_parity_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic [2:0]           ps2c_q, ps2d_q;
  logic                 fall;
  logic [3:0]           bit_cnt_q;
  logic [9:0]           frame_q;
  logic [TW-1:0]        to_q;
  logic                 wr_q, perr_q;
  logic [7:0]           wr_byte_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          fcnt_q, fcnt_d;
  logic                 ready_q, ovf_q, full, push, pop;
  logic [7:0]           rd_byte;
  state_t               state_q;
  logic [7:0]           code_q;
  logic                 ext_q, pressed_q, valid_q, brk_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 mk_vld, mk_ext, bk_vld, bk_ext;

  // Stage 0 catches the raw line; a falling edge is stage 2 high while stage 1 is low.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2c_q <= '0;
      ps2d_q <= '0;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[1:0], ps2_data};
    end
  end

  assign fall = ps2c_q[2] & ~ps2c_q[1];

  // Frame assembly: bits shift in from the top, so after 10 samples frame_q[0] is the start bit.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_q <= '0;
      frame_q   <= '0;
      to_q      <= '0;
      wr_q      <= 1'b0;
      perr_q    <= 1'b0;
      wr_byte_q <= '0;
    end else begin
      wr_q   <= 1'b0;
      perr_q <= 1'b0;
      if (fall) begin
        to_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          wr_byte_q <= frame_q[8:1];
          if (!frame_q[0] && ps2d_q[1]) begin
`ifdef PS2_PARITY_CHECK_EN
            if (^frame_q[9:1]) wr_q <= 1'b1;
            else               perr_q <= 1'b1;
`else
            wr_q <= 1'b1;
`endif
          end
        end else begin
          frame_q   <= {ps2d_q[1], frame_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        // A stalled partial frame is abandoned so the next start bit realigns the receiver.
        if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt_q <= '0;
          to_q      <= '0;
        end else begin
          to_q <= to_q + TW'(1);
        end
      end else begin
        to_q <= '0;
      end
    end
  end

  assign full    = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = ready_q & ~i_pause;
  assign push    = wr_q & (~full | pop);
  assign rd_byte = mem_q[rd_ptr_q];

  // Occupancy next-state; ready is registered from it so o_ready has no logic after the flop.
  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + (AW+1)'(1);
    else if (pop && !push) fcnt_d = fcnt_q - (AW+1)'(1);
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_byte_q;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      fcnt_q  <= fcnt_d;
      ready_q <= (fcnt_d != '0);
      if (wr_q && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Classify the popped byte as a make or break event according to the prefix state.
  always_comb begin
    mk_vld = 1'b0;
    mk_ext = 1'b0;
    bk_vld = 1'b0;
    bk_ext = 1'b0;
    if (pop) begin
      case (state_q)
        IDLE:    if (rd_byte != 8'hE0 && rd_byte != 8'hF0) mk_vld = 1'b1;
        EXT:     if (rd_byte != 8'hF0) begin mk_vld = 1'b1; mk_ext = 1'b1; end
        BRK:     bk_vld = 1'b1;
        default: begin bk_vld = 1'b1; bk_ext = 1'b1; end
      endcase
    end
  end

  // Prefix FSM and registered key state; repeats of the held key are typematic and ignored.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      code_q    <= '0;
      ext_q     <= 1'b0;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
      if (pop) begin
        case (state_q)
          IDLE:    state_q <= (rd_byte == 8'hE0) ? EXT : (rd_byte == 8'hF0) ? BRK : IDLE;
          EXT:     state_q <= (rd_byte == 8'hF0) ? EXT_BRK : IDLE;
          default: state_q <= IDLE;
        endcase
      end
      if (mk_vld && !(pressed_q && rd_byte == code_q && mk_ext == ext_q)) begin
        code_q    <= rd_byte;
        ext_q     <= mk_ext;
        pressed_q <= 1'b1;
        cnt_q     <= cnt_q + CNT_WIDTH'(1);
        valid_q   <= 1'b1;
      end
      if (bk_vld && pressed_q && rd_byte == code_q && bk_ext == ext_q) begin
        pressed_q <= 1'b0;
        brk_q     <= 1'b1;
      end
    end
  end

  assign o_code     = code_q;
  assign o_ext      = ext_q;
  assign o_pressed  = pressed_q;
  assign o_cnt      = cnt_q;
  assign o_valid    = valid_q;
  assign o_brk      = brk_q;
  assign o_ready    = ready_q;
  assign o_overflow = ovf_q;
`ifdef PS2_PARITY_CHECK_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: doc/ps2_kbd_decoder.md
PS2_KBD_DECODER -- requirements
Module: ps2_kbd_decoder

Interface
Parameters:
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: byte FIFO entries; power of two, >=2.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the key-press counter.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000: idle clk cycles after which a partial frame is abandoned.

Ports:
REQ-004 SHALL have port clk  in  1  system clock; all state on its rising edge.
REQ-005 SHALL have port clrn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports ps2_clk, ps2_data  in  1 each  raw PS/2 lines, asynchronous to clk.
REQ-007 SHALL have port i_pause  in  1  1 = decoder stops popping the FIFO.
REQ-008 SHALL have port o_code  out  8  last make scan code, without prefix.
REQ-009 SHALL have port o_ext  out  1  o_code carried an E0 prefix.
REQ-010 SHALL have port o_pressed  out  1  key in o_code/o_ext currently held.
REQ-011 SHALL have port o_cnt  out  CNT_WIDTH  count of distinct make events.
REQ-012 SHALL have port o_valid  out  1  one-cycle pulse per new make event.
REQ-013 SHALL have port o_brk  out  1  one-cycle pulse when the held key is released.
REQ-014 SHALL have port o_ready  out  1  FIFO not empty.
REQ-015 SHALL have port o_overflow  out  1  sticky; a byte was lost.
REQ-016 SHALL have port o_parity_err  out  1  one-cycle pulse per bad-parity frame.

Function
REQ-017 SHALL pass ps2_clk and ps2_data through 3-stage synchronisers, detect a ps2_clk falling edge as old=1/new=0, and sample ps2_data on that edge.
REQ-018 SHALL assemble 11-bit frames (start, 8 data LSB first, odd parity, stop) using a bit counter 0..10.
REQ-019 SHALL accept a frame only if start=0 and stop=1; otherwise the frame is discarded silently and the counter returns to 0.
REQ-020 SHALL return the bit counter to 0 without writing when a frame is partial and no falling edge has occurred for TIMEOUT_CYC cycles.
REQ-021 SHALL write an accepted byte to the FIFO in the cycle after the stop-bit sample.
REQ-022 SHALL drop the byte and set o_overflow when a write hits a full FIFO, except that a simultaneous pop frees the slot so the write succeeds; o_overflow clears only on reset.
REQ-023 SHALL pop one byte per cycle when o_ready=1 and i_pause=0.
REQ-024 SHALL run the decoder FSM with states IDLE, EXT, BRK, EXT_BRK:
  - IDLE+E0 -> EXT
  - IDLE+F0 -> BRK
  - EXT+F0 -> EXT_BRK
  - any other byte in IDLE/EXT -> make event (ext=state==EXT), then IDLE
  - any byte in BRK/EXT_BRK -> break event (ext=state==EXT_BRK), then IDLE
  - E0 in BRK/EXT/EXT_BRK is treated as a data byte
REQ-025 SHALL treat a make that matches {o_code,o_ext} while o_pressed=1 as typematic repeat: no output change, no o_valid, no count.
REQ-026 SHALL, on any other make, load o_code/o_ext, set o_pressed=1, increment o_cnt (wrap to 0 at max), and pulse o_valid.
REQ-027 SHALL, on a break matching {o_code,o_ext}, clear o_pressed and pulse o_brk with o_code retained; non-matching breaks are ignored.
REQ-028 SHALL register all outputs; o_valid/o_brk assert exactly 2 cycles after the FIFO write of the final byte, given i_pause=0 and the FIFO was empty.

Reset
REQ-029 SHALL, while clrn=0, asynchronously clear synchronisers, bit counter, timeout counter, FIFO pointers, and FSM (->IDLE); o_code=0, o_ext=0, o_pressed=0, o_cnt=0, o_valid=0, o_brk=0, o_ready=0, o_overflow=0, o_parity_err=0.
REQ-030 SHALL discard a frame in progress when reset is asserted mid-frame; the first full frame after release is received correctly.

Configuration
REQ-031 SHALL, with macro PS2_PARITY_CHECK_EN defined, discard frames whose 9 data+parity bits have even parity and pulse o_parity_err in the cycle the write would have occurred.
REQ-032 SHALL, with PS2_PARITY_CHECK_EN undefined, ignore parity and tie o_parity_err to 0.

Verification
REQ-033 SHALL cover: frame 0x1C -> o_code=0x1C, o_ext=0, o_pressed=1, o_cnt=1, single o_valid pulse.
REQ-034 SHALL cover: 1C,1C,1C,F0,1C -> o_cnt=1, one o_valid, one o_brk, o_pressed=0, o_code=0x1C.
REQ-035 SHALL cover: E0,75 then E0,F0,75 -> o_code=0x75, o_ext=1, o_pressed 1 then 0; F0,75 alone gives no o_brk.
REQ-036 SHALL cover: i_pause=1, send FIFO_DEPTH+1 distinct makes -> o_overflow=1; release pause -> exactly FIFO_DEPTH o_valid pulses, o_cnt=FIFO_DEPTH.
REQ-037 SHALL cover: 5 bits, idle TIMEOUT_CYC+1 cycles, then frame 0x2A -> o_code=0x2A; and a bad-parity frame -> dropped plus o_parity_err pulse with macro, accepted without it.
